kan_layer_seq: RTL and testbench
================================

Name: kan_layer_seq

Overview:
- Parametrised successor to the fixed 64x64 Chebyshev KAN layer.
- Takes a full per-input activation vector (IN_DIM independent inputs, no broadcast) and produces OUT_DIM outputs: y[j] = sat( sum over i,n of c[i][n][j] * T_n(x[i]) ).
- Generates Chebyshev terms internally with a shared recurrence. Coefficients are streamed from an external single-port coefficient ROM/RAM.
- All OUT_DIM lanes multiply-accumulate in parallel. Sits between activation buffers and the next KAN layer.

Parameters:
- IN_DIM, 4, number of input features.
- OUT_DIM, 4, number of output lanes (parallel MACs).
- WIDTH, 16, signed data/coefficient width.
- FRAC, 12, fractional bits (Q-format; 1.0 = 1<<FRAC). Constraint: FRAC <= WIDTH-2.
- DEGREE, 3, highest Chebyshev order (terms 0..DEGREE).
- ACC_W, WIDTH+8, signed accumulator width per lane.

Ports:
- clk, input, 1, clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a computation; sampled only in IDLE.
- x_vec, input, IN_DIM*WIDTH, signed inputs; x[i] = x_vec[i*WIDTH +: WIDTH]; latched on accepted start.
- coef_rd_en, output, 1, coefficient read strobe.
- coef_rd_addr, output, max(1,$clog2(IN_DIM*(DEGREE+1))), read address = i*(DEGREE+1)+n.
- coef_rd_data, input, OUT_DIM*WIDTH, lane j coeff at [j*WIDTH +: WIDTH]; valid exactly 1 cycle after coef_rd_en.
- busy, output, 1, high from the accepted start until done.
- done, output, 1, one-cycle completion pulse.
- sat, output, OUT_DIM, per-lane saturation flag for the last result.
- y_vec, output, OUT_DIM*WIDTH, signed results; lane j at [j*WIDTH +: WIDTH].

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, coef_rd_en=0, coef_rd_addr=0, sat=0, y_vec=0; accumulators and T registers cleared.
- States:
  - IDLE: start=1 latches x_vec, clears accumulators, sets busy, goes to RUN.
  - RUN: issues N = IN_DIM*(DEGREE+1) reads on consecutive cycles with coef_rd_en=1. The first read is in the cycle right after the start edge. Address order: i outer ascending, n inner ascending. After the last read, goes to DRAIN.
  - DRAIN: performs the final accumulate (1 cycle), then goes to OUTPUT.
  - OUTPUT: registers saturated y_vec and sat, pulses done=1, clears busy, returns to IDLE.
- Latency: done is high in the cycle N+2 edges after the start-sampling edge. y_vec and sat update on that same edge and hold until the next completion.
- start while busy is ignored; no queuing. start in the done cycle is ignored; it is accepted from the following cycle.
- Chebyshev terms are computed at issue time and registered alongside the address so they align with the returned data:
  - T0 = 1<<FRAC.
  - T1 = x[i].
  - Tn = sat_W( ((2*x[i]*T(n-1)) >>> FRAC) - T(n-2) ).
  - Intermediates are full precision; sat_W clamps to [-2^(WIDTH-1), 2^(WIDTH-1)-1].
  - The recurrence restarts at n=0 for each new i.
- Per-lane product p = (c*Tn) >>> FRAC: 2*WIDTH signed, arithmetic shift (floor), sign-extended to ACC_W.
- Accumulator: acc = sat_ACC(acc + p). If clamping occurs at any step, the lane's internal overflow flag is set.
- Output: y[j] = sat_W(acc[j]). sat[j] = 1 if the output clamp or the accumulator overflow flag fired during this run.
- Lanes are fully independent; the T path is shared across lanes.
- coef_rd_addr holds its last value when coef_rd_en=0.

Test Plan (WIDTH=16, FRAC=12, DEGREE=3, IN_DIM=2, OUT_DIM=2, N=8):
- Reset values: assert rst_n=0 -> all outputs 0. Release, start=1 -> busy=1, exactly 8 coef_rd_en cycles with addresses 0..7, done pulse 10 edges after start, busy=0 after.
- Constant term: c[i][0][j]=4096, all other coeffs 0, any x -> y=8192 on both lanes, sat=0.
- Recurrence: x=2048 (0.5) on both inputs, only c[i][3][j]=4096 -> T2=-2048, T3=-4096, y=-8192 on both lanes.
- Lane independence: x0=1024, x1=0; lane0 c[i][1]=4096, lane1 c[i][1]=-4096 -> y0=1024, y1=-1024.
- Saturation: all c[i][0][0]=32767 and c[i][0][1]=-32768 -> y0=32767, y1=-32768, sat=2'b11. Next run with zero coeffs -> y=0, sat=0.
- Start while busy: pulse start at RUN cycle 3 -> ignored, still 8 reads and one done. Then assert rst_n=0 mid-RUN -> immediate IDLE, outputs 0. A new start then completes correctly with y=8192 under the constant-term coeffs.

Source files
------------

// File: rtl/kan_layer_seq.sv
// kan_layer_seq: sequential Chebyshev KAN layer. Streams coefficients from an external memory,
// builds T_n(x[i]) with a shared recurrence and runs OUT_DIM saturating MAC lanes in parallel.
module kan_layer_seq #(
  parameter int IN_DIM = 4,
  parameter int OUT_DIM = 4,
  parameter int WIDTH = 16,
  parameter int FRAC = 12,
  parameter int DEGREE = 3,
  parameter int ACC_W = WIDTH + 8,
  localparam int N = IN_DIM * (DEGREE + 1),
  localparam int AW = (N > 1) ? $clog2(N) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [IN_DIM*WIDTH-1:0]    x_vec,
  output logic                       coef_rd_en,
  output logic [AW-1:0]              coef_rd_addr,
  input  logic [OUT_DIM*WIDTH-1:0]   coef_rd_data,
  output logic                       busy,
  output logic                       done,
  output logic [OUT_DIM-1:0]         sat,
  output logic [OUT_DIM*WIDTH-1:0]   y_vec
);
  localparam int IW = (IN_DIM > 1) ? $clog2(IN_DIM) : 1;
  localparam int NW = (DEGREE > 0) ? $clog2(DEGREE + 1) : 1;
  localparam int TW = 2 * WIDTH + 2;
  localparam int PW = 2 * WIDTH;
  localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;
  localparam logic signed [WIDTH-1:0] ONE = WIDTH'(1 << FRAC);
  localparam logic signed [WIDTH-1:0] W_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] W_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] A_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] A_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, OUTP} state_t;
  state_t state;

  logic signed [WIDTH-1:0] x_q [IN_DIM];
  logic [IW-1:0] i_cnt, i_nx;
  logic [NW-1:0] n_cnt, n_nx;
  logic signed [WIDTH-1:0] t_cur, t_prev, t_d, x_nx, t_nx;
  logic signed [TW-1:0] rec;
  logic wrap, last, v_d;
  logic signed [ACC_W-1:0] acc [OUT_DIM];
  logic [OUT_DIM-1:0] ovf, acc_of, y_of;
  logic signed [PW-1:0] prod [OUT_DIM];
  logic signed [SW-1:0] sum [OUT_DIM];
  logic signed [ACC_W-1:0] acc_nx [OUT_DIM];
  logic signed [WIDTH-1:0] y_nx [OUT_DIM];

  // Next term to issue: t_cur/t_prev hold T(n-1)/T(n-2) of the read currently on the bus
  always_comb begin
    wrap = n_cnt == NW'(DEGREE);
    last = coef_rd_addr == AW'(N - 1);
    n_nx = wrap ? '0 : n_cnt + NW'(1);
    i_nx = wrap ? i_cnt + IW'(1) : i_cnt;
    x_nx = '0;
    for (int k = 0; k < IN_DIM; k++)
      x_nx = (i_nx == IW'(k)) ? x_q[k] : x_nx;
    rec = ((TW'(x_nx) * TW'(t_cur) * TW'(2)) >>> FRAC) - TW'(t_prev);
    t_nx = (n_nx == '0) ? ONE :
           (n_nx == NW'(1)) ? x_nx :
           (rec > TW'(W_MAX)) ? W_MAX :
           (rec < TW'(W_MIN)) ? W_MIN : rec[WIDTH-1:0];
  end

  always_comb begin
    for (int j = 0; j < OUT_DIM; j++) begin
      prod[j] = PW'($signed(coef_rd_data[j*WIDTH +: WIDTH])) * PW'(t_d);
      sum[j] = SW'(acc[j]) + SW'(prod[j] >>> FRAC);
      acc_of[j] = (sum[j] > SW'(A_MAX)) || (sum[j] < SW'(A_MIN));
      acc_nx[j] = (sum[j] > SW'(A_MAX)) ? A_MAX :
                  (sum[j] < SW'(A_MIN)) ? A_MIN : sum[j][ACC_W-1:0];
      y_of[j] = (acc[j] > ACC_W'(W_MAX)) || (acc[j] < ACC_W'(W_MIN));
      y_nx[j] = (acc[j] > ACC_W'(W_MAX)) ? W_MAX :
                (acc[j] < ACC_W'(W_MIN)) ? W_MIN : acc[j][WIDTH-1:0];
    end
  end

  // Data for a read returns one cycle later, so the term and a valid bit are delayed by one stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      coef_rd_en <= 1'b0;
      coef_rd_addr <= '0;
      sat <= '0;
      y_vec <= '0;
      i_cnt <= '0;
      n_cnt <= '0;
      t_cur <= '0;
      t_prev <= '0;
      t_d <= '0;
      v_d <= 1'b0;
      ovf <= '0;
      for (int k = 0; k < IN_DIM; k++) x_q[k] <= '0;
      for (int j = 0; j < OUT_DIM; j++) acc[j] <= '0;
    end else begin
      done <= 1'b0;
      v_d <= coef_rd_en;
      t_d <= t_cur;
      if (v_d)
        for (int j = 0; j < OUT_DIM; j++) begin
          acc[j] <= acc_nx[j];
          ovf[j] <= ovf[j] | acc_of[j];
        end
      case (state)
        IDLE: if (start && !done) begin
          for (int k = 0; k < IN_DIM; k++) x_q[k] <= x_vec[k*WIDTH +: WIDTH];
          for (int j = 0; j < OUT_DIM; j++) acc[j] <= '0;
          ovf <= '0;
          busy <= 1'b1;
          coef_rd_en <= 1'b1;
          coef_rd_addr <= '0;
          i_cnt <= '0;
          n_cnt <= '0;
          t_cur <= ONE;
          t_prev <= '0;
          state <= RUN;
        end
        RUN: if (last) begin
          coef_rd_en <= 1'b0;
          state <= DRAIN;
        end else begin
          coef_rd_addr <= coef_rd_addr + AW'(1);
          i_cnt <= i_nx;
          n_cnt <= n_nx;
          t_cur <= t_nx;
          t_prev <= t_cur;
        end
        DRAIN: state <= OUTP;
        default: begin
          for (int j = 0; j < OUT_DIM; j++) y_vec[j*WIDTH +: WIDTH] <= y_nx[j];
          sat <= y_of | ovf;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_kan_layer_seq.sv
// tb_kan_layer_seq: directed runs against an arithmetic reference model of the KAN layer.
module tb_kan_layer_seq;
  localparam int W = 16, IN = 2, OUT = 2, D = 3, N = IN * (D + 1);

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [IN*W-1:0] x_vec = '0;
  logic coef_rd_en;
  logic [2:0] coef_rd_addr;
  logic [OUT*W-1:0] coef_rd_data = '0;
  logic busy, done;
  logic [OUT-1:0] sat;
  logic [OUT*W-1:0] y_vec;

  logic signed [W-1:0] mem [N][OUT];
  int checks = 0, errors = 0;

  logic m_act = 1'b0, m_done = 1'b0;
  int m_cyc = 0, m_addr = 0;
  logic [OUT*W-1:0] m_y = '0;
  logic [OUT-1:0] m_sat = '0;
  logic [OUT+OUT*W-1:0] p_res = '0;

  kan_layer_seq #(.IN_DIM(IN), .OUT_DIM(OUT), .WIDTH(W), .FRAC(12), .DEGREE(D), .ACC_W(W + 8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x_vec(x_vec),
    .coef_rd_en(coef_rd_en), .coef_rd_addr(coef_rd_addr), .coef_rd_data(coef_rd_data),
    .busy(busy), .done(done), .sat(sat), .y_vec(y_vec));

  always #5 clk = ~clk;

  always @(posedge clk)
    if (coef_rd_en)
      for (int j = 0; j < OUT; j++) coef_rd_data[j*W +: W] <= mem[coef_rd_addr][j];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint clampw(input longint v, input int w);
    longint hi;
    hi = (longint'(1) << (w - 1)) - 1;
    return (v > hi) ? hi : (v < -hi - 1) ? -hi - 1 : v;
  endfunction

  function automatic logic [OUT+OUT*W-1:0] model(input logic [IN*W-1:0] xv);
    longint t[D+1];
    longint acc[OUT];
    longint x, c;
    logic [OUT-1:0] s;
    logic [OUT*W-1:0] y;
    s = '0;
    y = '0;
    for (int j = 0; j < OUT; j++) acc[j] = 0;
    for (int i = 0; i < IN; i++) begin
      x = $signed(xv[i*W +: W]);
      t[0] = 4096;
      t[1] = x;
      for (int n = 2; n <= D; n++) t[n] = clampw(((2 * x * t[n-1]) >>> 12) - t[n-2], W);
      for (int n = 0; n <= D; n++)
        for (int j = 0; j < OUT; j++) begin
          c = mem[i*(D+1)+n][j];
          acc[j] = acc[j] + ((c * t[n]) >>> 12);
          if (clampw(acc[j], W + 8) != acc[j]) begin
            s[j] = 1'b1;
            acc[j] = clampw(acc[j], W + 8);
          end
        end
    end
    for (int j = 0; j < OUT; j++) begin
      y[j*W +: W] = 16'(clampw(acc[j], W));
      if (clampw(acc[j], W) != acc[j]) s[j] = 1'b1;
    end
    return {s, y};
  endfunction

  // Reference timeline: reads on cycles 0..N-1 after the accepting edge, done on cycle N+2
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_act <= 1'b0;
      m_done <= 1'b0;
      m_cyc <= 0;
      m_addr <= 0;
      m_y <= '0;
      m_sat <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_act) begin
        m_cyc <= m_cyc + 1;
        if (m_cyc + 1 < N) m_addr <= m_cyc + 1;
        if (m_cyc + 1 == N + 2) begin
          m_act <= 1'b0;
          m_done <= 1'b1;
          m_y <= p_res[OUT*W-1:0];
          m_sat <= p_res[OUT+OUT*W-1:OUT*W];
        end
      end else if (start && !m_done) begin
        m_act <= 1'b1;
        m_cyc <= 0;
        m_addr <= 0;
        p_res <= model(x_vec);
      end
    end
  end

  always @(negedge clk) begin
    check("busy", busy, m_act);
    check("done", done, m_done);
    check("rd_en", coef_rd_en, m_act && m_cyc < N);
    check("rd_addr", coef_rd_addr, m_addr);
    check("y_vec", y_vec, m_y);
    check("sat", sat, m_sat);
  end

  task automatic set_coef(input int n_sel, input logic signed [W-1:0] c0, input logic signed [W-1:0] c1);
    for (int a = 0; a < N; a++) begin
      mem[a][0] = 0;
      mem[a][1] = 0;
    end
    for (int i = 0; i < IN; i++) begin
      mem[i*(D+1)+n_sel][0] = c0;
      mem[i*(D+1)+n_sel][1] = c1;
    end
  endtask

  task automatic run(input logic signed [W-1:0] x0, input logic signed [W-1:0] x1, input int pulse_k,
                     input longint ey0, input longint ey1, input longint esat);
    int k, nrd;
    k = 0;
    nrd = 0;
    @(negedge clk);
    x_vec = {x1, x0};
    start = 1'b1;
    while (k < 40) begin
      @(negedge clk);
      if (k == 0) begin
        start = 1'b0;
        check("busy_after_start", busy, 1);
      end
      if (k == pulse_k) start = 1'b1;
      if (k == pulse_k + 1) start = 1'b0;
      if (coef_rd_en) nrd++;
      if (done) break;
      k++;
    end
    check("done_latency", k, N + 2);
    check("rd_count", nrd, N);
    check("y0", $signed(y_vec[W-1:0]), ey0);
    check("y1", $signed(y_vec[2*W-1:W]), ey1);
    check("sat_bits", sat, esat);
    @(negedge clk);
    start = 1'b0;
    check("busy_after_done", busy, 0);
  endtask

  initial begin
    set_coef(0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", coef_rd_en, 0);
    check("rst_addr", coef_rd_addr, 0);
    check("rst_y", y_vec, 0);
    check("rst_sat", sat, 0);
    rst_n = 1'b1;
    set_coef(0, 4096, 4096);
    run(1000, -3000, -5, 8192, 8192, 0);
    set_coef(3, 4096, 4096);
    run(2048, 2048, -5, -8192, -8192, 0);
    set_coef(1, 4096, -4096);
    run(1024, 0, -5, 1024, -1024, 0);
    set_coef(0, 32767, -32768);
    run(-700, 3300, -5, 32767, -32768, 3);
    set_coef(0, 0, 0);
    run(1234, -4321, N + 2, 0, 0, 0);
    set_coef(0, 4096, 4096);
    run(-2048, 777, 3, 8192, 8192, 0);
    set_coef(3, 4096, 4096);
    @(negedge clk);
    x_vec = {16'sd2048, 16'sd2048};
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_rd_en", coef_rd_en, 0);
    check("midrst_addr", coef_rd_addr, 0);
    check("midrst_y", y_vec, 0);
    check("midrst_sat", sat, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    set_coef(0, 4096, 4096);
    run(500, 500, -5, 8192, 8192, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
